// File: rtl/matrix_io_sequencer.sv
// Load/capture/display sequencer between serial board inputs and a systolic array.
// Optional MATRIX_IO_SEQUENCER_REPLAY_EN adds replay_i to re-show the last buffered job.
module matrix_io_sequencer #(
    parameter int width_p        = 8,
    parameter int array_width_p  = 2,
    parameter int array_height_p = 2,
    parameter int num_inputs_p   = 8,
    parameter int dwell_cycles_p = 60000000,
    localparam int num_outputs   = array_width_p * array_height_p,
    localparam int idx_w         = (num_outputs > 1) ? $clog2(num_outputs) : 1
) (
`ifdef MATRIX_IO_SEQUENCER_REPLAY_EN
    input  logic               replay_i,
`endif
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               flush_i,
    input  logic               bit_valid_i,
    input  logic               bit_i,
    output logic               arr_valid_o,
    output logic [width_p-1:0] arr_data_o,
    input  logic               arr_ready_i,
    input  logic               res_valid_i,
    input  logic [width_p-1:0] res_data_i,
    output logic               res_yumi_o,
    output logic               disp_valid_o,
    output logic [width_p-1:0] disp_data_o,
    output logic [idx_w-1:0]   disp_index_o,
    output logic [1:0]         state_o
);

    localparam int bit_cnt_w  = $clog2(width_p + 1);
    localparam int word_cnt_w = $clog2(num_inputs_p + 1);
    localparam int wr_ptr_w   = $clog2(num_outputs + 1);
    localparam int dwell_w    = $clog2(dwell_cycles_p + 1);

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DISPLAY = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [width_p-1:0]    shift_q, shift_d;
    logic [bit_cnt_w-1:0]  bit_cnt_q, bit_cnt_d;
    logic                  arr_valid_q, arr_valid_d;
    logic [width_p-1:0]    arr_data_q, arr_data_d;
    logic [word_cnt_w-1:0] word_cnt_q, word_cnt_d;
    logic [width_p-1:0]    res_buf_q [num_outputs];
    logic [width_p-1:0]    res_buf_d [num_outputs];
    logic [wr_ptr_w-1:0]   wr_ptr_q, wr_ptr_d;
    logic [idx_w-1:0]      rd_ptr_q, rd_ptr_d;
    logic [dwell_w-1:0]    dwell_cnt_q, dwell_cnt_d;
    logic [width_p-1:0]    shift_next;
`ifdef MATRIX_IO_SEQUENCER_REPLAY_EN
    logic                  buf_valid_q, buf_valid_d;
`endif

    assign res_yumi_o   = (state_q == ST_COMPUTE) && res_valid_i;
    assign arr_valid_o  = arr_valid_q;
    assign arr_data_o   = arr_data_q;
    assign disp_valid_o = (state_q == ST_DISPLAY);
    assign disp_data_o  = disp_valid_o ? res_buf_q[rd_ptr_q] : '0;
    assign disp_index_o = rd_ptr_q;
    assign state_o      = state_q;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        arr_valid_d = arr_valid_q;
        arr_data_d  = arr_data_q;
        word_cnt_d  = word_cnt_q;
        res_buf_d   = res_buf_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        dwell_cnt_d = dwell_cnt_q;
        shift_next  = (shift_q << 1) | width_p'(bit_i);
`ifdef MATRIX_IO_SEQUENCER_REPLAY_EN
        buf_valid_d = buf_valid_q;
`endif

        case (state_q)
            ST_LOAD: begin
                // A pending word blocks the shifter until the array takes it.
                if (arr_valid_q) begin
                    if (arr_ready_i) begin
                        arr_valid_d = 1'b0;
                        if (word_cnt_q == word_cnt_w'(num_inputs_p - 1)) begin
                            word_cnt_d = '0;
                            state_d    = ST_COMPUTE;
                        end else begin
                            word_cnt_d = word_cnt_q + word_cnt_w'(1);
                        end
                    end
                end else if (bit_valid_i) begin
`ifdef MATRIX_IO_SEQUENCER_REPLAY_EN
                    buf_valid_d = 1'b0;
`endif
                    if (bit_cnt_q == bit_cnt_w'(width_p - 1)) begin
                        arr_data_d  = shift_next;
                        arr_valid_d = 1'b1;
                        shift_d     = '0;
                        bit_cnt_d   = '0;
                    end else begin
                        shift_d   = shift_next;
                        bit_cnt_d = bit_cnt_q + bit_cnt_w'(1);
                    end
                end
`ifdef MATRIX_IO_SEQUENCER_REPLAY_EN
                else if (replay_i && buf_valid_q && (word_cnt_q == '0)) begin
                    state_d     = ST_DISPLAY;
                    rd_ptr_d    = '0;
                    dwell_cnt_d = '0;
                end
`endif
            end
            ST_COMPUTE: begin
                if (res_yumi_o) begin
                    res_buf_d[wr_ptr_q[idx_w-1:0]] = res_data_i;
                    if (wr_ptr_q == wr_ptr_w'(num_outputs - 1)) begin
                        wr_ptr_d = '0;
                        state_d  = ST_DISPLAY;
`ifdef MATRIX_IO_SEQUENCER_REPLAY_EN
                        buf_valid_d = 1'b1;
`endif
                    end else begin
                        wr_ptr_d = wr_ptr_q + wr_ptr_w'(1);
                    end
                end
            end
            ST_DISPLAY: begin
                if (dwell_cnt_q == dwell_w'(dwell_cycles_p - 1)) begin
                    dwell_cnt_d = '0;
                    if (rd_ptr_q == idx_w'(num_outputs - 1)) begin
                        rd_ptr_d = '0;
                        state_d  = ST_LOAD;
                    end else begin
                        rd_ptr_d = rd_ptr_q + idx_w'(1);
                    end
                end else begin
                    dwell_cnt_d = dwell_cnt_q + dwell_w'(1);
                end
            end
            default: state_d = ST_LOAD;
        endcase

        // Flush returns everything to the reset image, discarding any handshake.
        if (flush_i) begin
            state_d     = ST_LOAD;
            shift_d     = '0;
            bit_cnt_d   = '0;
            arr_valid_d = 1'b0;
            arr_data_d  = '0;
            word_cnt_d  = '0;
            res_buf_d   = '{default: '0};
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            dwell_cnt_d = '0;
`ifdef MATRIX_IO_SEQUENCER_REPLAY_EN
            buf_valid_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= ST_LOAD;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            arr_valid_q <= 1'b0;
            arr_data_q  <= '0;
            word_cnt_q  <= '0;
            res_buf_q   <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            dwell_cnt_q <= '0;
`ifdef MATRIX_IO_SEQUENCER_REPLAY_EN
            buf_valid_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            arr_valid_q <= arr_valid_d;
            arr_data_q  <= arr_data_d;
            word_cnt_q  <= word_cnt_d;
            res_buf_q   <= res_buf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            dwell_cnt_q <= dwell_cnt_d;
`ifdef MATRIX_IO_SEQUENCER_REPLAY_EN
            buf_valid_q <= buf_valid_d;
`endif
        end
    end

endmodule

// File: tb/tb_matrix_io_sequencer.sv
// Scoreboard bench for matrix_io_sequencer: stimulus pushes expected array words and
// display samples into queues, a monitor pops and compares them as the DUT presents them.
module tb_matrix_io_sequencer;

    localparam int W     = 8;
    localparam int DWELL = 4;
    localparam int NOUT  = 4;
    localparam int IDXW  = 2;

    logic            clk_i = 1'b0;
    logic            reset_n_i;
    logic            flush_i;
    logic            bit_valid_i;
    logic            bit_i;
    logic            arr_valid_o;
    logic [W-1:0]    arr_data_o;
    logic            arr_ready_i;
    logic            res_valid_i;
    logic [W-1:0]    res_data_i;
    logic            res_yumi_o;
    logic            disp_valid_o;
    logic [W-1:0]    disp_data_o;
    logic [IDXW-1:0] disp_index_o;
    logic [1:0]      state_o;
`ifdef MATRIX_IO_SEQUENCER_REPLAY_EN
    logic            replay_i;
`endif

    matrix_io_sequencer #(
        .width_p(W), .array_width_p(2), .array_height_p(2),
        .num_inputs_p(8), .dwell_cycles_p(DWELL)
    ) dut (
`ifdef MATRIX_IO_SEQUENCER_REPLAY_EN
        .replay_i(replay_i),
`endif
        .clk_i(clk_i), .reset_n_i(reset_n_i), .flush_i(flush_i),
        .bit_valid_i(bit_valid_i), .bit_i(bit_i),
        .arr_valid_o(arr_valid_o), .arr_data_o(arr_data_o), .arr_ready_i(arr_ready_i),
        .res_valid_i(res_valid_i), .res_data_i(res_data_i), .res_yumi_o(res_yumi_o),
        .disp_valid_o(disp_valid_o), .disp_data_o(disp_data_o),
        .disp_index_o(disp_index_o), .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    int checkCount = 0;
    int passCount  = 0;
    logic [W-1:0]        arrQ  [$];
    logic [IDXW+W-1:0]   dispQ [$];
    logic [W-1:0]        expArr;
    logic [IDXW+W-1:0]   expDisp;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, " arr_valid"}, arr_valid_o, 0);
        checkOutput({tag, " arr_data"}, arr_data_o, 0);
        checkOutput({tag, " res_yumi"}, res_yumi_o, 0);
        checkOutput({tag, " disp_valid"}, disp_valid_o, 0);
        checkOutput({tag, " disp_data"}, disp_data_o, 0);
        checkOutput({tag, " disp_index"}, disp_index_o, 0);
        checkOutput({tag, " state"}, state_o, 0);
    endtask

    // Shifts one word in MSB first, one strobe per cycle.
    task automatic applyStimulus(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) begin
            bit_valid_i = 1'b1;
            bit_i       = w[i];
            step();
        end
        bit_valid_i = 1'b0;
    endtask

    task automatic sendWord(input logic [W-1:0] w);
        int n;
        applyStimulus(w);
        arrQ.push_back(w);
        checkOutput("word valid after last bit", arr_valid_o, 1);
        checkOutput("word data after last bit", arr_data_o, w);
        n = 0;
        while (arr_valid_o && n < 50) begin
            step();
            n++;
        end
        checkOutput("handshake within budget", arr_valid_o, 0);
    endtask

    task automatic pushDisplay(input logic [W-1:0] res [NOUT]);
        for (int r = 0; r < NOUT; r++)
            for (int d = 0; d < DWELL; d++)
                dispQ.push_back({IDXW'(r), res[r]});
    endtask

    task automatic applyResults(input logic [W-1:0] res [NOUT]);
        pushDisplay(res);
        for (int r = 0; r < NOUT; r++) begin
            res_valid_i = 1'b1;
            res_data_i  = res[r];
            #1;
            checkOutput("res_yumi in compute", res_yumi_o, 1);
            step();
        end
        res_data_i = 8'h99;
        #1;
        checkOutput("state display after last result", state_o, 2);
        checkOutput("extra result not consumed", res_yumi_o, 0);
        res_valid_i = 1'b0;
    endtask

    task automatic waitState(input logic [1:0] s, input int budget, input string name);
        int n;
        n = 0;
        while (state_o !== s && n < budget) begin
            step();
            n++;
        end
        checkOutput(name, state_o, s);
    endtask

    task automatic sendJob(input logic [W-1:0] words [8]);
        for (int i = 0; i < 8; i++) begin
            sendWord(words[i]);
            checkOutput("state after word", state_o, (i == 7) ? 32'd1 : 32'd0);
        end
    endtask

    // Monitor: compares every accepted array word and every displayed sample.
    initial begin
        forever begin
            @(negedge clk_i);
            if (reset_n_i && !flush_i && arr_valid_o && arr_ready_i) begin
                if (arrQ.size() == 0) begin
                    checkCount++;
                    $display("[TB] FAIL unexpected arr word: got 0x%0h, expected none", arr_data_o);
                end else begin
                    expArr = arrQ.pop_front();
                    checkOutput("arr word at handshake", arr_data_o, expArr);
                end
            end
            if (disp_valid_o) begin
                if (dispQ.size() == 0) begin
                    checkCount++;
                    $display("[TB] FAIL unexpected display: got idx %0d data 0x%0h, expected none",
                             disp_index_o, disp_data_o);
                end else begin
                    expDisp = dispQ.pop_front();
                    checkOutput("display idx/data", {disp_index_o, disp_data_o}, expDisp);
                end
            end
        end
    end

    initial begin
        #200000;
        checkCount++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("%0d/%0d checks passed", passCount, checkCount);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        reset_n_i = 1'b0; flush_i = 1'b0; bit_valid_i = 1'b0; bit_i = 1'b0;
        arr_ready_i = 1'b1; res_valid_i = 1'b0; res_data_i = '0;
`ifdef MATRIX_IO_SEQUENCER_REPLAY_EN
        replay_i = 1'b0;
`endif
        step(); step();
        checkIdle("reset");
        reset_n_i = 1'b1;
        step();

        $display("[TB] reset mid-load");
        for (int i = 0; i < 5; i++) begin
            bit_valid_i = 1'b1; bit_i = 1'b1;
            step();
        end
        bit_valid_i = 1'b0;
        reset_n_i = 1'b0;
        step();
        checkIdle("mid-load reset");
        reset_n_i = 1'b1;
        step();
        sendWord(8'h3C);

        $display("[TB] load and res_yumi gating");
        res_valid_i = 1'b1; res_data_i = 8'hEE;
        #1;
        checkOutput("res_yumi outside compute", res_yumi_o, 0);
        res_valid_i = 1'b0;
        step();
        sendWord(8'hA5);

        $display("[TB] backpressure");
        arr_ready_i = 1'b0;
        applyStimulus(8'h5A);
        arrQ.push_back(8'h5A);
        for (int c = 0; c < 10; c++) begin
            bit_valid_i = (c == 1 || c == 4 || c == 7);
            bit_i       = 1'b1;
            step();
            checkOutput("stalled valid", arr_valid_o, 1);
            checkOutput("stalled data", arr_data_o, 8'h5A);
        end
        bit_valid_i = 1'b0;
        arr_ready_i = 1'b1;
        step();
        checkOutput("released handshake", arr_valid_o, 0);
        sendWord(8'h01); sendWord(8'h80); sendWord(8'hFF);
        sendWord(8'h00);
        checkOutput("state after 7 words", state_o, 0);
        sendWord(8'h7E);
        checkOutput("state compute after 8 words", state_o, 1);

        $display("[TB] capture and display");
        applyResults('{8'h11, 8'h22, 8'h33, 8'h44});
        waitState(2'd0, 40, "display returns to load");
        checkOutput("disp_valid after display", disp_valid_o, 0);
        checkOutput("display queue drained", dispQ.size(), 0);

`ifdef MATRIX_IO_SEQUENCER_REPLAY_EN
        $display("[TB] replay");
        pushDisplay('{8'h11, 8'h22, 8'h33, 8'h44});
        replay_i = 1'b1;
        step();
        replay_i = 1'b0;
        checkOutput("replay enters display", state_o, 2);
        waitState(2'd0, 40, "replay returns to load");
        checkOutput("replay queue drained", dispQ.size(), 0);
        bit_valid_i = 1'b1; bit_i = 1'b1;
        step();
        bit_valid_i = 1'b0;
        replay_i = 1'b1;
        step();
        replay_i = 1'b0;
        checkOutput("replay ignored after bit", state_o, 0);
        step();
        checkOutput("replay still ignored", disp_valid_o, 0);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
`endif

        $display("[TB] flush during display");
        sendJob('{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17});
        applyResults('{8'hA1, 8'hB2, 8'hC3, 8'hD4});
        n = 0;
        while (!(disp_valid_o && disp_index_o == 2) && n < 40) begin
            step();
            n++;
        end
        checkOutput("reached display index 2", disp_index_o, 2);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        checkIdle("after flush");
        dispQ.delete();

        $display("[TB] flush coincident with handshake");
        arr_ready_i = 1'b0;
        applyStimulus(8'h77);
        checkOutput("word pending before flush", arr_valid_o, 1);
        arr_ready_i = 1'b1;
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        checkIdle("flush on handshake");

        $display("[TB] fresh job after flush");
        sendJob('{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28});
        applyResults('{8'h01, 8'h02, 8'h03, 8'h04});
        waitState(2'd0, 40, "fresh job returns to load");
        checkOutput("fresh display drained", dispQ.size(), 0);
        checkOutput("arr queue drained", arrQ.size(), 0);

        step();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
